demux_ternario_doble: RTL and testbench

DEMUX_TERNARIO_DOBLE -- requirements
Module: demux_ternario_doble

---
 rtl/demux_ternario_doble_pkg.sv | 23 ++
 rtl/demux_ternario_doble_contador_canal.sv | 21 ++
 rtl/demux_ternario_doble.sv | 120 ++++++++++++
 tb/tb_demux_ternario_doble.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_ternario_doble_pkg.sv
// Shared FSM state and destination codes for the three-way demultiplexer.
// Also holds the select decode so the core and anyone else share one rule.
package demux_ternario_doble_pkg;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    typedef enum logic [1:0] {
        DEST_A = 2'd0,
        DEST_B = 2'd1,
        DEST_C = 2'd2
    } dest_t;

    localparam int NUM_CANALES = 3;

    // s2 has priority so that s1 is a don't-care whenever c is chosen
    function automatic dest_t decodificar_destino(input logic s1, input logic s2);
        return s2 ? DEST_C : (s1 ? DEST_B : DEST_A);
    endfunction

endpackage

// File: rtl/demux_ternario_doble_contador_canal.sv
// 8-bit wrapping delivered-word counter for one output channel.
module contador_canal (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    output logic [7:0] cuenta
);

    logic [7:0] cuenta_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cuenta_reg <= 8'd0;
        end else if (en) begin
            cuenta_reg <= cuenta_reg + 8'd1;
        end
    end

    assign cuenta = cuenta_reg;

endmodule

// File: rtl/demux_ternario_doble.sv
// One-word buffered 1-to-3 demultiplexer with valid/ready on every port.
// Define DEMUX_CONTADORES_EN to add per-channel delivered-word counters.
module demux_ternario_doble
    import demux_ternario_doble_pkg::*;
#(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ANCHO-1:0] d_in,
    input  logic             s1,
    input  logic             s2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ANCHO-1:0] a_out,
    output logic [ANCHO-1:0] b_out,
    output logic [ANCHO-1:0] c_out,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
`ifdef DEMUX_CONTADORES_EN
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b,
    output logic [7:0]       cnt_c,
`endif
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready
);

    estado_t          state_reg, state_next;
    dest_t            dest_reg, dest_next;
    logic [ANCHO-1:0] data_reg, data_next;

    logic [NUM_CANALES-1:0] ready_vec;
    logic [NUM_CANALES-1:0] valid_vec;
    logic [ANCHO-1:0]       out_vec [NUM_CANALES];
    logic                   transfer_in;
    logic                   transfer_out;

    assign ready_vec = {c_ready, b_ready, a_ready};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= VACIO;
            dest_reg  <= DEST_A;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            dest_reg  <= dest_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dest_next    = dest_reg;
        data_next    = data_reg;
        transfer_out = (state_reg == LLENO) && ready_vec[dest_reg];
        // A full buffer can only take a new word in the cycle it drains
        in_ready     = (state_reg == VACIO) ? 1'b1 : ready_vec[dest_reg];
        transfer_in  = in_valid && in_ready;

        case (state_reg)
            VACIO: begin
                if (transfer_in) begin
                    state_next = LLENO;
                    dest_next  = decodificar_destino(s1, s2);
                    data_next  = d_in;
                end
            end
            LLENO: begin
                if (transfer_out) begin
                    if (transfer_in) begin
                        dest_next = decodificar_destino(s1, s2);
                        data_next = d_in;
                    end else begin
                        state_next = VACIO;
                    end
                end
            end
            default: state_next = VACIO;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CANALES; gi++) begin : g_canal
            assign valid_vec[gi] = (state_reg == LLENO) && (dest_reg == dest_t'(gi));
            assign out_vec[gi]   = valid_vec[gi] ? data_reg : '0;
        end
    endgenerate

    assign a_valid = valid_vec[0];
    assign b_valid = valid_vec[1];
    assign c_valid = valid_vec[2];
    assign a_out   = out_vec[0];
    assign b_out   = out_vec[1];
    assign c_out   = out_vec[2];

`ifdef DEMUX_CONTADORES_EN
    logic [7:0] cnt_vec [NUM_CANALES];

    generate
        for (gi = 0; gi < NUM_CANALES; gi++) begin : g_contador
            contador_canal u_contador (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (valid_vec[gi] && ready_vec[gi]),
                .cuenta  (cnt_vec[gi])
            );
        end
    endgenerate

    assign cnt_a = cnt_vec[0];
    assign cnt_b = cnt_vec[1];
    assign cnt_c = cnt_vec[2];
`endif

endmodule

// File: tb/tb_demux_ternario_doble.sv
// Randomised and directed bench for demux_ternario_doble against a queue-based model.
// Counter checks are compiled in when DEMUX_CONTADORES_EN is defined.
module tb_demux_ternario_doble;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] d_in;
    logic       s1, s2, in_valid;
    logic       a_ready, b_ready, c_ready;
    logic       in_ready;
    logic [7:0] a_out, b_out, c_out;
    logic       a_valid, b_valid, c_valid;
`ifdef DEMUX_CONTADORES_EN
    logic [7:0] cnt_a, cnt_b, cnt_c;
`endif

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [7:0] data;
        int         dest;
    } item_t;

    item_t      q[$];
    logic [7:0] cnt_m [3];
    logic [2:0] vld;
    logic [7:0] outs [3];

    always #5 clk = ~clk;

    assign vld = {c_valid, b_valid, a_valid};
    assign outs[0] = a_out;
    assign outs[1] = b_out;
    assign outs[2] = c_out;

    demux_ternario_doble #(.ANCHO(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .d_in     (d_in),
        .s1       (s1),
        .s2       (s2),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_out    (a_out),
        .b_out    (b_out),
        .c_out    (c_out),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .c_valid  (c_valid),
`ifdef DEMUX_CONTADORES_EN
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .cnt_c    (cnt_c),
`endif
        .a_ready  (a_ready),
        .b_ready  (b_ready),
        .c_ready  (c_ready)
    );

    function automatic logic head_ready();
        logic [2:0] r;
        r = {c_ready, b_ready, a_ready};
        if (q.size() == 0) return 1'b0;
        return r[q[0].dest];
    endfunction

    function automatic logic m_in_ready();
        return (q.size() == 0) || head_ready();
    endfunction

    // Advance one cycle and update the model from the values present at the edge
    task automatic tick();
        logic       go_in, go_out;
        int         dst;
        logic [7:0] dd;
        go_in  = in_valid && m_in_ready();
        go_out = head_ready();
        dst    = s2 ? 2 : (s1 ? 1 : 0);
        dd     = d_in;
        @(posedge clk);
        if (go_out) begin
            cnt_m[q[0].dest] = cnt_m[q[0].dest] + 8'd1;
            void'(q.pop_front());
        end
        if (go_in) q.push_back('{data: dd, dest: dst});
        @(negedge clk);
    endtask

    task automatic set_in(input logic [7:0] d, input logic v1, input logic v2, input logic iv,
                          input logic ar, input logic br, input logic cr);
        d_in = d; s1 = v1; s2 = v2; in_valid = iv;
        a_ready = ar; b_ready = br; c_ready = cr;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        for (int i = 0; i < 3; i++) cnt_m[i] = 8'd0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (vld !== 3'b000 || a_out !== 8'h00 || b_out !== 8'h00 || c_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b a=%h b=%h c=%h, required valid=000 outs=00", vld, a_out, b_out, c_out);
        end
        do_reset();
        set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        $display("reset: checked outputs and in_ready");
    endtask

    task automatic test_route();
        set_in(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (vld !== 3'b001 || a_out !== 8'h5A || b_out !== 8'h00 || c_out !== 8'h00) begin
            errors++;
            $display("FAIL route_a: valid=%b a=%h b=%h c=%h, required valid=001 a=5a b=00 c=00", vld, a_out, b_out, c_out);
        end
        tick();
        $display("route: 5a -> a");
    endtask

    task automatic test_select();
        set_in(8'h3C, 1'bx, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        set_in(8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (vld !== 3'b100 || c_out !== 8'h3C) begin
            errors++;
            $display("FAIL select_c: valid=%b c=%h, required valid=100 c=3c", vld, c_out);
        end
        tick();
        set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (vld !== 3'b010 || b_out !== 8'h11 || c_out !== 8'h00) begin
            errors++;
            $display("FAIL select_b: valid=%b b=%h c=%h, required valid=010 b=11 c=00", vld, b_out, c_out);
        end
        tick();
        $display("select: 3c -> c, 11 -> b");
    endtask

    task automatic test_backpressure();
        set_in(8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
            vectors++;
            if (b_valid !== 1'b1 || b_out !== 8'h77 || in_ready !== 1'b0 || vld !== 3'b010) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b b=%h in_ready=%b, required valid=010 b=77 in_ready=0", i, vld, b_out, in_ready);
            end
            tick();
        end
        set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (in_ready !== 1'b1 || b_valid !== 1'b1 || b_out !== 8'h77) begin
            errors++;
            $display("FAIL backpressure_release: b_valid=%b b=%h in_ready=%b, required 1/77/1", b_valid, b_out, in_ready);
        end
        tick();
        vectors++;
        if (vld !== 3'b000) begin
            errors++;
            $display("FAIL backpressure_drained: valid=%b, required 000", vld);
        end
        $display("backpressure: 77 held 5 cycles on b then delivered");
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [4];
        int         dests [4];
        logic [7:0] exp_o;
        words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        dests = '{0, 1, 2, 0};
        for (int i = 0; i <= 4; i++) begin
            if (i < 4)
                set_in(words[i], dests[i] == 1, dests[i] == 2, 1'b1, 1'b1, 1'b1, 1'b1);
            else
                set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            if (i > 0) begin
                exp_o = words[i-1];
                vectors++;
                if (vld !== 3'(1 << dests[i-1]) || outs[dests[i-1]] !== exp_o || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: valid=%b out=%h in_ready=%b, required valid=%b out=%h in_ready=1",
                             i - 1, vld, outs[dests[i-1]], in_ready, 3'(1 << dests[i-1]), exp_o);
                end
            end
            tick();
        end
        $display("back_to_back: a,b,c,a one per cycle");
    endtask

    task automatic test_reset_mid();
        set_in(8'hE7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (a_valid !== 1'b1 || a_out !== 8'hE7) begin
            errors++;
            $display("FAIL reset_mid_loaded: a_valid=%b a=%h, required 1/e7", a_valid, a_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (a_valid !== 1'b0 || a_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: a_valid=%b a=%h, required 0/00", a_valid, a_out);
        end
        do_reset();
        set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (vld !== 3'b000 || a_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_mid_dropped[%0d]: valid=%b a=%h, required 000/00", i, vld, a_out);
            end
            tick();
        end
`ifdef DEMUX_CONTADORES_EN
        vectors++;
        if (cnt_a !== 8'd0 || cnt_b !== 8'd0 || cnt_c !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_counters: %0d/%0d/%0d, required 0/0/0", cnt_a, cnt_b, cnt_c);
        end
`endif
        $display("reset_mid: held word e7 dropped");
    endtask

    task automatic test_random();
        logic       ev;
        logic [7:0] eo;
        for (int n = 0; n < 400; n++) begin
            set_in(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
            vectors++;
            if (in_ready !== m_in_ready()) begin
                errors++;
                $display("FAIL random_in_ready[%0d]: got %b, required %b", n, in_ready, m_in_ready());
            end
            for (int ch = 0; ch < 3; ch++) begin
                ev = (q.size() != 0) && (q[0].dest == ch);
                eo = ev ? q[0].data : 8'h00;
                vectors++;
                if (vld[ch] !== ev || outs[ch] !== eo) begin
                    errors++;
                    $display("FAIL random_ch%0d[%0d]: valid=%b out=%h, required %b/%h", ch, n, vld[ch], outs[ch], ev, eo);
                end
            end
`ifdef DEMUX_CONTADORES_EN
            vectors++;
            if (cnt_a !== cnt_m[0] || cnt_b !== cnt_m[1] || cnt_c !== cnt_m[2]) begin
                errors++;
                $display("FAIL random_cnt[%0d]: %0d/%0d/%0d, required %0d/%0d/%0d", n, cnt_a, cnt_b, cnt_c, cnt_m[0], cnt_m[1], cnt_m[2]);
            end
`endif
            tick();
        end
        $display("random: 400 cycles compared against model");
    endtask

`ifdef DEMUX_CONTADORES_EN
    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) begin
            set_in(8'(i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            tick();
        end
        set_in(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        vectors++;
        if (cnt_c !== 8'd0 || cnt_a !== 8'd0 || cnt_b !== 8'd0 || vld !== 3'b000) begin
            errors++;
            $display("FAIL counter_wrap: a=%0d b=%0d c=%0d valid=%b, required 0/0/0/000", cnt_a, cnt_b, cnt_c, vld);
        end
        $display("counter_wrap: 256 words to c, cnt_c=%0d", cnt_c);
    endtask
`endif

    initial begin
        for (int i = 0; i < 3; i++) cnt_m[i] = 8'd0;
        @(negedge clk);
        test_reset();
        test_route();
        test_select();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef DEMUX_CONTADORES_EN
        test_counter_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
